// File: rtl/horner_ctrl.sv
// horner_ctrl: sequences an external 8-bit ALU to evaluate a degree-DEGREE
// polynomial in unsigned Q4.4 with Horner's scheme.
// acc starts at c[DEGREE]; each step is acc = acc*x (MUL) then acc = acc +/- c[k] (ADD).
module horner_ctrl #(
  parameter int unsigned DEGREE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] x_i,
  input  logic       coef_we_i,
  input  logic [2:0] coef_addr_i,
  input  logic [7:0] coef_i,
  input  logic       coef_sign_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] result_o,
  output logic       ovf_o,
  output logic [7:0] alu_op_a_o,
  output logic [7:0] alu_op_b_o,
  output logic       alu_sigma_n_o,
  output logic [2:0] alu_mode_o,
  input  logic [7:0] alu_res_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] MODE_ADD_SUB = 3'd2;
  localparam logic [2:0] MODE_MUL     = 3'd3;
  localparam logic [2:0] MODE_IDLE    = 3'd4;

  localparam logic [2:0] K_TOP    = 3'(DEGREE);
  localparam logic [2:0] K_TOP_M1 = 3'(DEGREE - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] x_r_q, x_r_d;
  logic [2:0] k_q, k_d;
  logic       ovf_q, ovf_d;
  logic [7:0] c_mag_q [0:DEGREE];
  logic [7:0] c_mag_d [0:DEGREE];
  logic       c_sgn_q [0:DEGREE];
  logic       c_sgn_d [0:DEGREE];

  logic       busy;
  logic       accept;
  logic       coef_hit;
  logic [7:0] cur_mag;
  logic       cur_sgn;
  logic       add_wrap;

  assign busy     = (state_q == S_LOAD) || (state_q == S_MUL) || (state_q == S_ADD);
  assign accept   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign coef_hit = coef_we_i && !busy && (32'(coef_addr_i) <= DEGREE);

  assign busy_o   = busy;
  assign done_o   = (state_q == S_DONE);
  assign result_o = acc_q;
  assign ovf_o    = ovf_q;

  // Select coefficient k for the ADD step (mux loop keeps index width tied to DEGREE)
  always_comb begin
    cur_mag = '0;
    cur_sgn = 1'b0;
    for (int unsigned i = 0; i <= DEGREE; i++) begin
      if (k_q == 3'(i)) begin
        cur_mag = c_mag_q[i];
        cur_sgn = c_sgn_q[i];
      end
    end
  end

  // Wrap detect: an add that wraps lands below acc, a subtract that borrows lands above it
  always_comb begin
    if (cur_sgn) add_wrap = (alu_res_i > acc_q);
    else         add_wrap = (alu_res_i < acc_q);
  end

  // Coefficient register file write port, only while the sequencer is not busy
  always_comb begin
    for (int unsigned i = 0; i <= DEGREE; i++) begin
      c_mag_d[i] = c_mag_q[i];
      c_sgn_d[i] = c_sgn_q[i];
      if (coef_hit && (coef_addr_i == 3'(i))) begin
        c_mag_d[i] = coef_i;
        c_sgn_d[i] = coef_sign_i;
      end
    end
  end

  // Sequencer next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_r_d   = x_r_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          x_r_d   = x_i;
          ovf_d   = 1'b0;
          k_d     = K_TOP;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // leading coefficient is always taken as positive
        acc_d   = c_mag_q[DEGREE];
        k_d     = K_TOP_M1;
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d   = alu_res_i;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d = alu_res_i;
        ovf_d = ovf_q | add_wrap;
        if (k_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q - 3'd1;
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: purely a function of state, acc, x_r and k
  always_comb begin
    alu_mode_o    = MODE_IDLE;
    alu_op_a_o    = acc_q;
    alu_op_b_o    = '0;
    alu_sigma_n_o = 1'b0;
    case (state_q)
      S_MUL: begin
        alu_mode_o = MODE_MUL;
        alu_op_b_o = x_r_q;
      end
      S_ADD: begin
        alu_mode_o    = MODE_ADD_SUB;
        alu_op_b_o    = cur_mag;
        alu_sigma_n_o = cur_sgn;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      x_r_q   <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i <= DEGREE; i++) begin
        c_mag_q[i] <= '0;
        c_sgn_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_r_q   <= x_r_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i <= DEGREE; i++) begin
        c_mag_q[i] <= c_mag_d[i];
        c_sgn_q[i] <= c_sgn_d[i];
      end
    end
  end

endmodule

// File: tb/tb_horner_ctrl.sv
// Testbench for horner_ctrl: directed vector table, hand-written corner sequences
// and randomized evaluations against a plain-arithmetic polynomial model.
module tb_horner_ctrl;

  localparam int unsigned D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] x_i = '0;
  logic       coef_we_i = 1'b0;
  logic [2:0] coef_addr_i = '0;
  logic [7:0] coef_i = '0;
  logic       coef_sign_i = 1'b0;
  logic       busy_o, done_o, ovf_o, alu_sigma_n_o;
  logic [7:0] result_o, alu_op_a_o, alu_op_b_o, alu_res_i;
  logic [2:0] alu_mode_o;

  horner_ctrl #(.DEGREE(D)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_i(coef_i),
    .coef_sign_i(coef_sign_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .ovf_o(ovf_o), .alu_op_a_o(alu_op_a_o),
    .alu_op_b_o(alu_op_b_o), .alu_sigma_n_o(alu_sigma_n_o),
    .alu_mode_o(alu_mode_o), .alu_res_i(alu_res_i)
  );

  always #5 clk = ~clk;

  // Zero-latency ALU: Q4.4 multiply (truncated) and mod-256 add/sub
  logic [15:0] prod;
  always_comb begin
    prod = 16'(alu_op_a_o) * 16'(alu_op_b_o);
    case (alu_mode_o)
      3'd3:    alu_res_i = prod[11:4];
      3'd2:    alu_res_i = alu_sigma_n_o ? (alu_op_a_o - alu_op_b_o) : (alu_op_a_o + alu_op_b_o);
      default: alu_res_i = 8'h00;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cycles = 0;

  always @(posedge clk) if (done_o) done_cycles++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model of the coefficient registers as the requester believes them to be
  logic [7:0] m_mag [0:7];
  logic       m_sgn [0:7];

  function automatic logic [8:0] ref_eval(input logic [7:0] x);
    int  acc;
    bit  ovf;
    acc = int'(m_mag[D]);
    ovf = 0;
    for (int k = int'(D) - 1; k >= 0; k--) begin
      acc = ((acc * int'(x)) / 16) % 256;
      if (m_sgn[k]) acc = acc - int'(m_mag[k]);
      else          acc = acc + int'(m_mag[k]);
      if (acc < 0)   begin acc += 256; ovf = 1; end
      if (acc > 255) begin acc -= 256; ovf = 1; end
    end
    return {ovf, 8'(acc)};
  endfunction

  task automatic write_coef(input logic [2:0] a, input logic [7:0] m, input logic s);
    coef_we_i = 1'b1; coef_addr_i = a; coef_i = m; coef_sign_i = s;
    @(negedge clk);
    coef_we_i = 1'b0;
    if (32'(a) <= D) begin m_mag[a] = m; m_sgn[a] = s; end
  endtask

  // Values injected at cycle inj of a run (start pulse plus coefficient write while busy)
  logic [7:0] inj_x, inj_mag;
  logic [2:0] inj_addr;
  logic       inj_sgn;

  // Start an evaluation at the current negedge and follow it to DONE (bounded)
  task automatic run_eval(input logic [7:0] x, input int inj,
                          output int lat, output int bcnt, output logic [23:0] tr);
    int cyc;
    start_i = 1'b1; x_i = x;
    cyc = 0; bcnt = 0; tr = '0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        start_i = 1'b1; x_i = inj_x;
        coef_we_i = 1'b1; coef_addr_i = inj_addr; coef_i = inj_mag; coef_sign_i = inj_sgn;
      end else begin
        start_i = 1'b0; coef_we_i = 1'b0;
      end
      if (busy_o) bcnt++;
      if (cyc <= 8) tr = {tr[20:0], alu_mode_o};
    end while (!done_o && cyc < 50);
    start_i = 1'b0; coef_we_i = 1'b0;
    lat = cyc - 1;
  endtask

  typedef struct {
    string           name;
    logic [3:0][7:0] mag;
    logic [3:0]      sgn;
    logic [7:0]      x;
    logic [7:0]      exp_y;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, bcnt, n;
    logic [23:0] tr;
    logic [8:0]  r;
    logic [7:0]  xr;

    vecs[0] = '{"basic",      {8'h10, 8'h20, 8'h00, 8'h08}, 4'b0001, 8'h10, 8'h28, 1'b0};
    vecs[1] = '{"lead_only",  {8'h10, 8'h00, 8'h00, 8'h00}, 4'b0000, 8'h20, 8'h80, 1'b0};
    vecs[2] = '{"add_wrap",   {8'hF0, 8'h20, 8'h00, 8'h00}, 4'b0000, 8'h10, 8'h10, 1'b1};
    vecs[3] = '{"sub_borrow", {8'h00, 8'h00, 8'h00, 8'h01}, 4'b0001, 8'h5A, 8'hFF, 1'b1};
    vecs[4] = '{"lead_sign",  {8'h10, 8'h00, 8'h00, 8'h00}, 4'b1000, 8'h10, 8'h10, 1'b0};
    vecs[5] = '{"mul_trunc",  {8'hFF, 8'h00, 8'h00, 8'h00}, 4'b0000, 8'hFF, 8'h10, 1'b0};

    for (int i = 0; i < 8; i++) begin m_mag[i] = '0; m_sgn[i] = 1'b0; end

    // Reset values while rst is held low
    #2;
    check("rst_busy",  32'(busy_o), 0);
    check("rst_done",  32'(done_o), 0);
    check("rst_res",   32'(result_o), 0);
    check("rst_ovf",   32'(ovf_o), 0);
    check("rst_mode",  32'(alu_mode_o), 4);
    check("rst_opa",   32'(alu_op_a_o), 0);
    check("rst_opb",   32'(alu_op_b_o), 0);
    check("rst_sigma", 32'(alu_sigma_n_o), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      for (int k = 0; k <= int'(D); k++)
        write_coef(3'(k), vecs[i].mag[k], vecs[i].sgn[k]);
      r = ref_eval(vecs[i].x);
      check({vecs[i].name, "_model"}, 32'(r), {23'd0, vecs[i].exp_ovf, vecs[i].exp_y});
      run_eval(vecs[i].x, 0, lat, bcnt, tr);
      check({vecs[i].name, "_lat"},   32'(lat), 2*D + 1);
      check({vecs[i].name, "_busy"},  32'(bcnt), 2*D + 1);
      check({vecs[i].name, "_trace"}, 32'(tr), 32'o43232324);
      check({vecs[i].name, "_y"},     32'(result_o), 32'(vecs[i].exp_y));
      check({vecs[i].name, "_ovf"},   32'(ovf_o), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check({vecs[i].name, "_done_once"}, 32'(done_o), 0);
      check({vecs[i].name, "_y_hold"},    32'(result_o), 32'(vecs[i].exp_y));
    end

    // Wrapped evaluation, then a new start clears ovf on acceptance
    for (int k = 0; k <= int'(D); k++) write_coef(3'(k), vecs[2].mag[k], vecs[2].sgn[k]);
    run_eval(8'h10, 0, lat, bcnt, tr);
    check("wrap_ovf_set", 32'(ovf_o), 1);
    start_i = 1'b1; x_i = 8'h10;
    @(negedge clk);
    start_i = 1'b0;
    check("ovf_clear_on_start", 32'(ovf_o), 0);
    check("load_busy", 32'(busy_o), 1);
    n = 0;
    while (!done_o && n < 50) begin @(negedge clk); n++; end
    check("wrap_rerun_y", 32'(result_o), 32'h10);

    // Start and a write while busy are both ignored
    for (int k = 0; k <= int'(D); k++) write_coef(3'(k), vecs[0].mag[k], vecs[0].sgn[k]);
    inj_x = 8'h30; inj_addr = 3'd0; inj_mag = 8'h7F; inj_sgn = 1'b0;
    run_eval(8'h10, 2, lat, bcnt, tr);
    check("busy_start_lat", 32'(lat), 2*D + 1);
    check("busy_start_y",   32'(result_o), 32'h28);

    // Start held in DONE with a same-edge write to the leading coefficient
    coef_we_i = 1'b1; coef_addr_i = 3'(D); coef_i = 8'h20; coef_sign_i = 1'b1;
    m_mag[D] = 8'h20; m_sgn[D] = 1'b1;
    r = ref_eval(8'h18);
    run_eval(8'h18, 0, lat, bcnt, tr);
    check("b2b_lat", 32'(lat), 2*D + 1);
    check("b2b_y",   32'(result_o), 32'(r[7:0]));
    check("b2b_ovf", 32'(ovf_o), 32'(r[8]));
    @(negedge clk);

    // Write beyond DEGREE is ignored
    write_coef(3'd7, 8'hAA, 1'b1);
    r = ref_eval(8'h18);
    run_eval(8'h18, 0, lat, bcnt, tr);
    check("hi_addr_y", 32'(result_o), 32'(r[7:0]));
    @(negedge clk);

    // Asynchronous reset during MUL
    start_i = 1'b1; x_i = 8'h10;
    n = 0;
    do begin @(negedge clk); start_i = 1'b0; n++; end while (alu_mode_o != 3'd3 && n < 20);
    check("reach_mul", 32'(alu_mode_o), 3);
    n = done_cycles;
    #1 rst = 1'b0;
    #1;
    check("arst_busy",  32'(busy_o), 0);
    check("arst_res",   32'(result_o), 0);
    check("arst_mode",  32'(alu_mode_o), 4);
    check("arst_opb",   32'(alu_op_b_o), 0);
    check("arst_sigma", 32'(alu_sigma_n_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_done", 32'(done_cycles), 32'(n));
    for (int i = 0; i < 8; i++) begin m_mag[i] = '0; m_sgn[i] = 1'b0; end
    run_eval(8'h37, 0, lat, bcnt, tr);
    check("arst_coef_zero_y",   32'(result_o), 0);
    check("arst_coef_zero_ovf", 32'(ovf_o), 0);
    @(negedge clk);

    // Randomized evaluations, some with ignored mid-run start/writes
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++)
        write_coef(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
      xr = 8'($urandom);
      r  = ref_eval(xr);
      inj_x = 8'($urandom); inj_addr = 3'($urandom_range(0, 3));
      inj_mag = 8'($urandom); inj_sgn = 1'($urandom);
      run_eval(xr, (it % 3 == 0) ? int'($urandom_range(1, 7)) : 0, lat, bcnt, tr);
      check("rand_lat", 32'(lat), 2*D + 1);
      check("rand_y",   32'(result_o), 32'(r[7:0]));
      check("rand_ovf", 32'(ovf_o), 32'(r[8]));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
